// File: rtl/counter_down_timer_pkg.sv
// +----------------------------------------------------------------------+
// | counter_down_timer_pkg : shared state encoding for the down timer    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package counter_down_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/counter_prescaler.sv
// +----------------------------------------------------------------------+
// | counter_prescaler : emits o_tick every (i_prescale+1) enabled cycles |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module counter_prescaler
  import counter_down_timer_pkg::*;
#(
  parameter int unsigned PRE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [PRE_WIDTH-1:0] i_prescale,
  output logic                 o_tick
);

  logic [PRE_WIDTH-1:0] cnt_q;

  // '>=' lets a lowered i_prescale fire immediately instead of wrapping.
  assign o_tick = enable && (cnt_q >= i_prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      if (o_tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + PRE_WIDTH'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_down_timer.sv
// +----------------------------------------------------------------------+
// | counter_down_timer : loadable down-counting timer, one-cycle o_done  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module counter_down_timer
  import counter_down_timer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PRE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load_en,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_auto_reload,
  input  logic [PRE_WIDTH-1:0] i_prescale,
  output logic [WIDTH-1:0]     number,
  output logic                 o_busy,
  output logic                 o_done
);

  state_e           state_q;
  logic [WIDTH-1:0] number_q;
  logic [WIDTH-1:0] reload_q;
  logic             done_q;
  logic             w_run;
  logic             w_clear;
  logic             w_tick;

  assign w_run   = (state_q == ST_RUN);
  assign w_clear = i_load_en || (i_stop && w_run);

  counter_prescaler #(
    .PRE_WIDTH (PRE_WIDTH)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (w_run),
    .clear      (w_clear),
    .i_prescale (i_prescale),
    .o_tick     (w_tick)
  );

  // Priority: load > stop > start > tick. A start while already running
  // falls through so it never swallows a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      number_q <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_load_en) begin
        number_q <= i_data;
        reload_q <= i_data;
        state_q  <= ST_IDLE;
      end else if (i_stop) begin
        if (w_run) begin
          state_q <= ST_PAUSED;
        end
      end else if (i_start && !w_run) begin
        if (number_q != '0) begin
          state_q <= ST_RUN;
        end
      end else if (w_tick) begin
        if (number_q == WIDTH'(1)) begin
          done_q <= 1'b1;
          if (i_auto_reload && (reload_q != '0)) begin
            number_q <= reload_q;
          end else begin
            number_q <= '0;
            state_q  <= ST_IDLE;
          end
        end else begin
          number_q <= number_q - WIDTH'(1);
        end
      end
    end
  end

  assign number = number_q;
  assign o_busy = w_run;
  assign o_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_down_timer.sv
// +----------------------------------------------------------------------+
// | tb_counter_down_timer : directed vector bench for counter_down_timer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_counter_down_timer;

  logic       clk;
  logic       rst_n;
  logic       i_load_en;
  logic [7:0] i_data;
  logic       i_start;
  logic       i_stop;
  logic       i_auto_reload;
  logic [3:0] i_prescale;
  logic [7:0] number;
  logic       o_busy;
  logic       o_done;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       ld;
    logic [7:0] data;
    logic       start;
    logic       stop;
    logic [7:0] exp_n;
    logic       exp_b;
    logic       exp_d;
  } vec_t;

  localparam int NVEC = 23;
  vec_t tbl [0:NVEC-1];

  counter_down_timer #(
    .WIDTH     (8),
    .PRE_WIDTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_load_en     (i_load_en),
    .i_data        (i_data),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_auto_reload (i_auto_reload),
    .i_prescale    (i_prescale),
    .number        (number),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] en, input logic eb, input logic ed);
    n_cmp++;
    if (number !== en || o_busy !== eb || o_done !== ed) begin
      n_bad++;
      $display("FAIL %s: got number=%0d busy=%0b done=%0b, expected number=%0d busy=%0b done=%0b",
               name, number, o_busy, o_done, en, eb, ed);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic ld, input logic [7:0] d, input logic st, input logic sp);
    @(negedge clk);
    i_load_en = ld;
    i_data    = d;
    i_start   = st;
    i_stop    = sp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    i_load_en = 1'b0; i_data = 8'd0; i_start = 1'b0; i_stop = 1'b0;
    i_auto_reload = 1'b0; i_prescale = 4'd0;

    //           ld    data   start stop  exp_n  busy  done
    tbl[0]  = '{1'b1, 8'd5, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'd7, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd7, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 8'd7, 1'b1, 1'b0, 8'd7, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 8'd2, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 8'd3, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0};
    tbl[21] = '{1'b1, 8'd9, 1'b0, 1'b0, 8'd9, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd9, 1'b0, 1'b0};

    #12;
    chk("reset_state", 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].ld, tbl[i].data, tbl[i].start, tbl[i].stop);
      chk($sformatf("vec%0d", i), tbl[i].exp_n, tbl[i].exp_b, tbl[i].exp_d);
    end

    // Auto-reload: load 3, prescale 2 -> o_done every 9 cycles.
    i_prescale = 4'd2;
    i_auto_reload = 1'b1;
    step(1'b1, 8'd3, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("ar_start", 8'd3, 1'b1, 1'b0);
    for (int k = 1; k <= 27; k++) begin
      step(1'b0, 8'd0, 1'b0, 1'b0);
      chk($sformatf("ar_k%0d", k), 8'(3 - ((k / 3) % 3)), 1'b1, (k % 9) == 0);
    end
    i_auto_reload = 1'b0;
    for (int k = 28; k <= 37; k++) begin
      step(1'b0, 8'd0, 1'b0, 1'b0);
      chk($sformatf("ar_off_k%0d", k),
          (k < 30) ? 8'd3 : (k < 33) ? 8'd2 : (k < 36) ? 8'd1 : 8'd0,
          k < 36, k == 36);
    end

    // Pause after two ticks, then resume.
    i_prescale = 4'd0;
    step(1'b1, 8'd6, 1'b0, 1'b0); chk("ps_load", 8'd6, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0); chk("ps_start", 8'd6, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0); chk("ps_t1", 8'd5, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0); chk("ps_t2", 8'd4, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1); chk("ps_stop", 8'd4, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0); chk("ps_hold1", 8'd4, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0); chk("ps_hold2", 8'd4, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0); chk("ps_resume", 8'd4, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0); chk("ps_r1", 8'd3, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0); chk("ps_r2", 8'd2, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0); chk("ps_r3", 8'd1, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0); chk("ps_r4", 8'd0, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b0); chk("ps_after", 8'd0, 1'b0, 1'b0);

    // Lower prescale from 15 to 1 mid-run: counter already past 1 ticks at once.
    i_prescale = 4'd15;
    step(1'b1, 8'd3, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0); chk("pr_start", 8'd3, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'd0, 1'b0, 1'b0);
      chk($sformatf("pr_slow%0d", k), 8'd3, 1'b1, 1'b0);
    end
    i_prescale = 4'd1;
    step(1'b0, 8'd0, 1'b0, 1'b0); chk("pr_fast0", 8'd2, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0); chk("pr_fast1", 8'd2, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0); chk("pr_fast2", 8'd1, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0); chk("pr_fast3", 8'd1, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0); chk("pr_done", 8'd0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a run.
    i_prescale = 4'd0;
    step(1'b1, 8'd9, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk("rs_pre", 8'd8, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async", 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk("rs_after", 8'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
